// File: rtl/serial_adc_reader.sv
// serial_adc_reader: frames one ADC conversion and shifts the serial data into a parallel sample.
// Optional free-running mode is enabled by defining SERIAL_ADC_CONTINUOUS_EN.
module serial_adc_reader #(
    parameter int FRAME_BITS    = 16,
    parameter int LEAD_BITS     = 4,
    parameter int DATA_BITS     = 12,
    parameter int QUIET_PERIODS = 2
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sclk_in,
    input  logic                 start,
    input  logic                 adc_sdata,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 busy,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_PERIODS + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, SHIFT, CAPTURE, TAIL, QUIET} state_t;

    state_t                state, state_nx;
    logic                  sclk_q, rise, fall, sync1, sync2, last_rise, quiet_done;
    logic [CW-1:0]         cnt;
    logic [QW-1:0]         qcnt;
    logic [FRAME_BITS-2:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nx;

    assign rise       = enable & sclk_in & ~sclk_q;
    assign fall       = enable & ~sclk_in & sclk_q;
    assign last_rise  = (state == SHIFT) && rise && (cnt == CW'(FRAME_BITS - 1));
    assign quiet_done = (state == QUIET) && fall && (qcnt == QW'(QUIET_PERIODS - 1));
    assign shreg_nx   = {shreg, sync2};
    assign busy       = state != IDLE;

    // state register
    always_ff @(posedge clk_in) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic; every transition is qualified by enable through rise/fall
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && enable) ? ALIGN : IDLE;
            ALIGN:   state_nx = fall ? SHIFT : ALIGN;
            SHIFT:   state_nx = last_rise ? CAPTURE : SHIFT;
            CAPTURE: state_nx = enable ? TAIL : CAPTURE;
            TAIL:    state_nx = fall ? QUIET : TAIL;
`ifdef SERIAL_ADC_CONTINUOUS_EN
            QUIET:   state_nx = !enable ? IDLE : quiet_done ? ALIGN : QUIET;
`else
            QUIET:   state_nx = quiet_done ? IDLE : QUIET;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // datapath: edge history, data sync, shifting, sample capture and ADC pins
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sclk_q       <= 1'b1;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            cnt          <= '0;
            qcnt         <= '0;
            shreg        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
        end else begin
            sclk_q       <= sclk_in;
            sync1        <= adc_sdata;
            sync2        <= sync1;
            sample_valid <= last_rise;
            adc_sclk     <= adc_cs_n | sclk_q;
            if (state == ALIGN && fall) begin
                adc_cs_n <= 1'b0;
                cnt      <= '0;
            end
            if (state == SHIFT && rise) begin
                shreg <= shreg_nx[FRAME_BITS-2:0];
                cnt   <= cnt + 1'b1;
            end
            if (last_rise) begin
                sample    <= shreg_nx[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
                frame_err <= |shreg_nx[FRAME_BITS-1 -: LEAD_BITS];
            end
            if (state == TAIL && fall) begin
                adc_cs_n <= 1'b1;
                qcnt     <= '0;
            end
            if (state == QUIET && fall) qcnt <= qcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_adc_reader.sv
// tb_serial_adc_reader: randomized checks of serial_adc_reader against a frame-level ADC model.
module tb_serial_adc_reader;
    logic        clk = 0, reset = 1, enable = 1, sclk_in = 1, start = 0, adc_sdata = 0;
    logic        adc_cs_n, adc_sclk, busy, sample_valid, frame_err;
    logic [11:0] sample;
    logic [15:0] adc_word = 16'h0;
    logic [3:0]  div = 0;
    logic        prev_cs = 1, prev_sclk = 1;
    int          bit_idx = 0, rise_cnt = 0, valid_cnt = 0, cs_falls = 0;
    int          vectors = 0, miscompares = 0;

    serial_adc_reader dut (
        .clk_in(clk), .reset(reset), .enable(enable), .sclk_in(sclk_in), .start(start),
        .adc_sdata(adc_sdata), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .busy(busy),
        .sample(sample), .sample_valid(sample_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // divider: sclk toggles every 16 clk cycles
    always @(posedge clk) begin
        div <= div + 1'b1;
        if (div == 4'd15) sclk_in <= ~sclk_in;
    end

    // ADC model: MSB out when cs_n falls, next bit after each adc_sclk rise; also event counters
    always @(negedge clk) begin
        if (prev_cs && !adc_cs_n) begin
            bit_idx = 15;
            adc_sdata = adc_word[15];
            cs_falls++;
        end else if (adc_cs_n === 1'b0 && !prev_sclk && adc_sclk) begin
            rise_cnt++;
            if (bit_idx > 0) begin
                bit_idx--;
                adc_sdata = adc_word[bit_idx];
            end
        end
        if (sample_valid === 1'b1) valid_cnt++;
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    task automatic pulse_start;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk); #1;
            if (sample_valid === 1'b1) ok = 1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) ok = 1;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({adc_cs_n, adc_sclk, busy, sample_valid, frame_err} !== 5'b11000 || sample !== 12'h0) begin
            miscompares++;
            $display("FAIL reset: cs_n/sclk/busy/valid/err=%b sample=%h required 11000 000",
                     {adc_cs_n, adc_sclk, busy, sample_valid, frame_err}, sample);
        end
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic test_frame(input logic [15:0] word, input string name);
        int  v0, r0, c0;
        bit  ok;
        logic [11:0] exp_s;
        logic        exp_e;
        exp_s = 12'(word % 16'd4096);
        exp_e = (word / 16'd4096) != 0;
        adc_word = word;
        v0 = valid_cnt; r0 = rise_cnt; c0 = cs_falls;
        repeat ($urandom_range(0, 40)) @(posedge clk);
        pulse_start();
        wait_valid(ok);
        vectors++;
        if (!ok || sample !== exp_s || frame_err !== exp_e) begin
            miscompares++;
            $display("FAIL %s sample: got %h err %b valid_seen %0d required %h err %b",
                     name, sample, frame_err, ok, exp_s, exp_e);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || valid_cnt - v0 != 1 || rise_cnt - r0 != 16 || cs_falls - c0 != 1 ||
            adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin
            miscompares++;
            $display("FAIL %s framing: idle %0d valids %0d rises %0d cs_falls %0d cs_n %b sclk %b required 1 1 16 1 1 1",
                     name, ok, valid_cnt - v0, rise_cnt - r0, cs_falls - c0, adc_cs_n, adc_sclk);
        end
    endtask

    task automatic test_start_while_busy;
        int  v0, c0;
        bit  ok;
        adc_word = 16'h0777;
        v0 = valid_cnt; c0 = cs_falls;
        pulse_start();
        for (int i = 0; i < 200 && adc_cs_n !== 1'b0; i++) @(posedge clk);
        repeat (50) @(posedge clk);
        pulse_start();
        wait_valid(ok);
        for (int i = 0; i < 200 && adc_cs_n !== 1'b1; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        pulse_start();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_quiet: busy %b required 1", busy);
        end
        wait_idle(ok);
        repeat (200) @(posedge clk);
        #1;
        vectors++;
        if (!ok || busy !== 1'b0 || valid_cnt - v0 != 1 || cs_falls - c0 != 1 || sample !== 12'h777) begin
            miscompares++;
            $display("FAIL start_while_busy: busy %b valids %0d cs_falls %0d sample %h required 0 1 1 777",
                     busy, valid_cnt - v0, cs_falls - c0, sample);
        end
    endtask

    task automatic test_reset_mid;
        int v0, r0;
        adc_word = 16'h0BCD;
        v0 = valid_cnt; r0 = rise_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && rise_cnt - r0 < 7; i++) @(posedge clk);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;
        vectors++;
        if (adc_cs_n !== 1'b1 || busy !== 1'b0 || rise_cnt - r0 != 7) begin
            miscompares++;
            $display("FAIL reset_mid: cs_n %b busy %b rises %0d required 1 0 7", adc_cs_n, busy, rise_cnt - r0);
        end
        reset = 0;
        repeat (600) @(posedge clk);
        #1;
        vectors++;
        if (valid_cnt != v0 || sample !== 12'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after: valids %0d sample %h busy %b required 0 000 0",
                     valid_cnt - v0, sample, busy);
        end
    endtask

    task automatic test_high_phase_start;
        bit ok = 0;
        for (int i = 0; i < 100 && !(sclk_in === 1'b1 && div == 4'd3); i++) @(posedge clk);
        #1;
        adc_word = 16'h0ACE;
        pulse_start();
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (sclk_in === 1'b0) ok = 1;
        end
        vectors++;
        if (!ok || adc_cs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL cs_early: cs_n %b at sclk fall (seen %0d) required 1", adc_cs_n, ok);
        end
        @(posedge clk); #1;
        vectors++;
        if (adc_cs_n !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_on_fall: cs_n %b one cycle after sclk fall required 0", adc_cs_n);
        end
        wait_idle(ok);
        vectors++;
        if (!ok || sample !== 12'hACE || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL high_phase_sample: sample %h err %b required ACE 0", sample, frame_err);
        end
    endtask

    task automatic test_enable;
        enable = 0;
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_low_start: busy %b cs_n %b required 0 1", busy, adc_cs_n);
        end
        enable = 1;
    endtask

    initial begin
        test_reset();
        test_frame(16'h0A5C, "a5c");
        test_frame(16'h8123, "lead_err");
        for (int i = 0; i < 6; i++) test_frame(16'($urandom), "random");
        test_start_while_busy();
        test_reset_mid();
        test_frame(16'($urandom_range(0, 4095)), "after_reset");
        test_high_phase_start();
        test_enable();
        test_frame(16'hF000, "all_lead");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
